// File: rtl/timer_ctrl.sv
// timer_ctrl: interval timer, one-shot/periodic, sticky irq with ack and overrun.
// Define TIMER_PRESCALE_EN to add the prescale port and step prescaler.

module timer_ctrl #(
  parameter int WIDTH     = 8,
  parameter int PRE_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     period,
`ifdef TIMER_PRESCALE_EN
  input  logic [PRE_WIDTH-1:0] prescale,
`endif
  input  logic                 irq_ack,
  output logic [WIDTH-1:0]     count,
  output logic                 busy,
  output logic                 tick,
  output logic                 irq,
  output logic                 overrun,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             irq_q, irq_d;
  logic             ovr_q, ovr_d;
  logic             err_q, err_d;

  logic start_ok;
  logic start_bad;
  logic step_en;
  logic expire;

  assign start_ok  = start && (period != '0);
  assign start_bad = start && (period == '0);

`ifdef TIMER_PRESCALE_EN
  logic [PRE_WIDTH-1:0] pre_q, pre_d;

  // Any start (accepted or not) and stop realign the step phase.
  always_comb begin
    pre_d = '0;
    if (state_q == RUN && !stop && !start
        && pre_q != prescale)
      pre_d = pre_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

  assign step_en = (state_q == RUN)
                && (pre_q == prescale);
`else
  logic [PRE_WIDTH-1:0] unused_pre;
  assign unused_pre = '0;
  assign step_en    = (state_q == RUN);
`endif

  assign expire = step_en
               && (count_q == per_q - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    priority case (1'b1)
      stop:      state_d = IDLE;
      start_ok:  state_d = RUN;
      start_bad: begin
        if (state_q == RUN) state_d = IDLE;
      end
      default: begin
        unique case (state_q)
          RUN:     if (expire && !mode_q) state_d = DONE;
          DONE:    if (irq_ack) state_d = IDLE;
          default: state_d = state_q;
        endcase
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    per_d   = per_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    err_d   = 1'b0;
    irq_d   = irq_q;
    ovr_d   = ovr_q;
    if (irq_ack) begin
      irq_d = 1'b0;
      ovr_d = 1'b0;
    end
    priority case (1'b1)
      stop: count_d = '0;
      start_ok: begin
        count_d = '0;
        per_d   = period;
        mode_d  = mode;
      end
      start_bad: begin
        err_d = 1'b1;
        if (state_q == RUN) count_d = '0;
      end
      expire: begin
        tick_d = 1'b1;
        irq_d  = 1'b1;
        // One-shot holds at period-1 for software to read back.
        if (mode_q) begin
          count_d = '0;
          if (irq_q && !irq_ack) ovr_d = 1'b1;
        end
      end
      step_en: count_d = count_q + 1'b1;
      default: begin
        if (state_q == DONE && irq_ack)
          count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      per_q   <= '0;
      mode_q  <= 1'b0;
      tick_q  <= 1'b0;
      irq_q   <= 1'b0;
      ovr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      per_q   <= per_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      irq_q   <= irq_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
    end
  end

  assign count   = count_q;
  assign busy    = (state_q == RUN);
  assign tick    = tick_q;
  assign irq     = irq_q;
  assign overrun = ovr_q;
  assign err     = err_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: scoreboard bench for timer_ctrl.
// Expected tick cycles are queued at start and matched as ticks appear.

module tb_timer_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         mode = 1'b0;
  logic         irq_ack = 1'b0;
  logic [W-1:0] period = '0;
`ifdef TIMER_PRESCALE_EN
  logic [3:0]   prescale = '0;
`endif
  logic [W-1:0] count;
  logic         busy, tick, irq, overrun, err;

  int cyc = 0;
  int npass = 0;
  int ntotal = 0;
  int exp_q[$];

  timer_ctrl #(.WIDTH(W), .PRE_WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .period   (period),
`ifdef TIMER_PRESCALE_EN
    .prescale (prescale),
`endif
    .irq_ack  (irq_ack),
    .count    (count),
    .busy     (busy),
    .tick     (tick),
    .irq      (irq),
    .overrun  (overrun),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tic();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [W-1:0] p, input logic m);
    period = p;
    mode   = m;
    start  = 1'b1;
    tic();
    start  = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tic();
    stop = 1'b0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tic();
    irq_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [W+4:0] o;
    tic();
    tic();
    o = {count, busy, tick, irq, overrun, err};
    ntotal++;
    if (o !== '0) $display("FAIL reset_init: got %0h required 0", o);
    else npass++;
    rst = 1'b0;
    do_start(10, 1'b1);
    for (int i = 0; i < 5; i++) tic();
    ntotal++;
    if ({busy, count} !== {1'b1, 8'd5})
      $display("FAIL reset_prerun: busy=%0b count=%0d required 1/5", busy, count);
    else npass++;
    #2 rst = 1'b1;
    #1;
    o = {count, busy, tick, irq, overrun, err};
    ntotal++;
    if (o !== '0) $display("FAIL reset_async: got %0h required 0", o);
    else npass++;
    #1 rst = 1'b0;
    tic();
    tic();
    ntotal++;
    if ({busy, count} !== '0)
      $display("FAIL reset_idle: busy=%0b count=%0d required 0/0", busy, count);
    else npass++;
  endtask

  task automatic test_oneshot();
    int k, e;
    do_start(4, 1'b0);
    k = cyc;
    ntotal++;
    if ({busy, count} !== {1'b1, 8'd0})
      $display("FAIL os_start: busy=%0b count=%0d required 1/0", busy, count);
    else npass++;
    exp_q.push_back(k + 4);
    for (int i = 0; i < 7; i++) begin
      tic();
      if (tick) begin
        ntotal++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        if (cyc !== e) $display("FAIL os_tick: tick at %0d required %0d", cyc, e);
        else npass++;
      end
    end
    ntotal++;
    if (exp_q.size() != 0) begin
      $display("FAIL os_missing: %0d ticks outstanding required 0", exp_q.size());
      exp_q.delete();
    end else npass++;
    ntotal++;
    if ({irq, busy, count} !== {1'b1, 1'b0, 8'd3})
      $display("FAIL os_done: irq=%0b busy=%0b count=%0d required 1/0/3", irq, busy, count);
    else npass++;
    do_ack();
    ntotal++;
    if ({irq, busy, count} !== '0)
      $display("FAIL os_ack: irq=%0b busy=%0b count=%0d required 0/0/0", irq, busy, count);
    else npass++;
  endtask

  task automatic test_periodic_overrun();
    int k, e;
    do_start(3, 1'b1);
    k = cyc;
    exp_q.push_back(k + 3);
    exp_q.push_back(k + 6);
    exp_q.push_back(k + 9);
    for (int i = 0; i < 11; i++) begin
      tic();
      if (tick) begin
        ntotal++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        if (cyc !== e) $display("FAIL per_tick: tick at %0d required %0d", cyc, e);
        else npass++;
      end
      if (cyc == k + 3) begin
        ntotal++;
        if ({irq, overrun} !== 2'b10)
          $display("FAIL per_first: irq=%0b ovr=%0b required 1/0", irq, overrun);
        else npass++;
      end
      if (cyc == k + 6) begin
        ntotal++;
        if ({irq, overrun} !== 2'b11)
          $display("FAIL per_overrun: irq=%0b ovr=%0b required 1/1", irq, overrun);
        else npass++;
      end
    end
    ntotal++;
    if (exp_q.size() != 0) begin
      $display("FAIL per_missing: %0d ticks outstanding required 0", exp_q.size());
      exp_q.delete();
    end else npass++;
    irq_ack = 1'b1;
    tic();
    irq_ack = 1'b0;
    ntotal++;
    if ({tick, irq, overrun} !== 3'b110)
      $display("FAIL per_ack_tick: tick=%0b irq=%0b ovr=%0b required 1/1/0", tick, irq, overrun);
    else npass++;
    do_ack();
    ntotal++;
    if ({tick, irq, overrun, busy} !== 4'b0001)
      $display("FAIL per_ack: tick=%0b irq=%0b ovr=%0b busy=%0b required 0/0/0/1",
               tick, irq, overrun, busy);
    else npass++;
    do_stop();
    do_ack();
  endtask

  task automatic test_boundaries();
    int k, e;
    do_start(0, 1'b1);
    ntotal++;
    if ({err, busy} !== 2'b10)
      $display("FAIL zero_err: err=%0b busy=%0b required 1/0", err, busy);
    else npass++;
    tic();
    ntotal++;
    if (err !== 1'b0) $display("FAIL zero_pulse: err=%0b required 0", err);
    else npass++;
    do_start(1, 1'b1);
    k = cyc;
    for (int j = 1; j <= 6; j++) exp_q.push_back(k + j);
    for (int i = 0; i < 6; i++) begin
      tic();
      if (tick) begin
        ntotal++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        if (cyc !== e) $display("FAIL p1_tick: tick at %0d required %0d", cyc, e);
        else npass++;
      end
    end
    ntotal++;
    if (exp_q.size() != 0 || count !== 8'd0) begin
      $display("FAIL p1_end: outstanding=%0d count=%0d required 0/0", exp_q.size(), count);
      exp_q.delete();
    end else npass++;
    do_stop();
    do_ack();
    do_start(255, 1'b1);
    k = cyc;
    exp_q.push_back(k + 255);
    exp_q.push_back(k + 510);
    for (int i = 0; i < 510; i++) begin
      tic();
      if (tick) begin
        ntotal++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        if (cyc !== e) $display("FAIL p255_tick: tick at %0d required %0d", cyc, e);
        else npass++;
      end
      if (cyc == k + 254) begin
        ntotal++;
        if (count !== 8'd254) $display("FAIL p255_max: count=%0d required 254", count);
        else npass++;
      end
    end
    ntotal++;
    if (exp_q.size() != 0) begin
      $display("FAIL p255_missing: %0d ticks outstanding required 0", exp_q.size());
      exp_q.delete();
    end else npass++;
    do_stop();
    do_ack();
  endtask

  task automatic test_priority();
    int k, e;
    do_start(4, 1'b1);
    tic();
    tic();
    ntotal++;
    if (count !== 8'd2) $display("FAIL pri_pre: count=%0d required 2", count);
    else npass++;
    do_start(4, 1'b1);
    k = cyc;
    ntotal++;
    if ({tick, busy, count} !== {2'b01, 8'd0})
      $display("FAIL pri_restart: tick=%0b busy=%0b count=%0d required 0/1/0", tick, busy, count);
    else npass++;
    exp_q.push_back(k + 4);
    for (int i = 0; i < 7; i++) begin
      tic();
      if (tick) begin
        ntotal++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        if (cyc !== e) $display("FAIL pri_tick: tick at %0d required %0d", cyc, e);
        else npass++;
      end
    end
    ntotal++;
    if (exp_q.size() != 0) begin
      $display("FAIL pri_missing: %0d ticks outstanding required 0", exp_q.size());
      exp_q.delete();
    end else npass++;
    do_stop();
    ntotal++;
    if ({tick, busy, count} !== '0)
      $display("FAIL pri_stop_due: tick=%0b busy=%0b count=%0d required 0/0/0", tick, busy, count);
    else npass++;
    do_start(5, 1'b1);
    tic();
    period = 8'd5;
    start  = 1'b1;
    stop   = 1'b1;
    tic();
    start  = 1'b0;
    stop   = 1'b0;
    ntotal++;
    if ({busy, count} !== '0)
      $display("FAIL pri_stop_start: busy=%0b count=%0d required 0/0", busy, count);
    else npass++;
    do_ack();
  endtask

  task automatic test_prescale();
    int k, e, ps;
`ifdef TIMER_PRESCALE_EN
    prescale = 4'd2;
    ps = 2;
`else
    ps = 0;
`endif
    do_start(3, 1'b1);
    k = cyc;
    exp_q.push_back(k + 3 * (ps + 1));
    exp_q.push_back(k + 6 * (ps + 1));
    for (int i = 0; i < 6 * (ps + 1) + 1; i++) begin
      tic();
      if (tick) begin
        ntotal++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        if (cyc !== e) $display("FAIL ps_tick: tick at %0d required %0d", cyc, e);
        else npass++;
      end
    end
    ntotal++;
    if (exp_q.size() != 0) begin
      $display("FAIL ps_missing: %0d ticks outstanding required 0", exp_q.size());
      exp_q.delete();
    end else npass++;
    do_stop();
    do_ack();
`ifdef TIMER_PRESCALE_EN
    prescale = '0;
`endif
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic_overrun();
    test_boundaries();
    test_priority();
    test_prescale();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
